// File: rtl/sudoku_pkg.sv
// Shared types, constants and small helpers for the Sudoku input controller.
// Cursor and digit arithmetic lives here so the top and the bench read the same way.
package sudoku_pkg;

    localparam int unsigned BOARD_N = 9;
    localparam int unsigned CELLS   = 81;

    typedef logic [3:0] digit_t;
    typedef digit_t [0:BOARD_N-1][0:BOARD_N-1] grid_t;
    typedef logic [0:BOARD_N-1][0:BOARD_N-1]   mask_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_UP,
        ACT_DOWN,
        ACT_LEFT,
        ACT_RIGHT,
        ACT_INC,
        ACT_CLR
    } action_t;

    typedef enum logic {
        IDLE,
        LOAD
    } ctrl_state_t;

    function automatic logic [3:0] wrap_inc(input logic [3:0] v);
        return (v == 4'(BOARD_N - 1)) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [3:0] wrap_dec(input logic [3:0] v);
        return (v == 4'd0) ? 4'(BOARD_N - 1) : v - 4'd1;
    endfunction

    function automatic digit_t digit_inc(input digit_t d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // ROM codes above 9 are not digits and load as an empty cell.
    function automatic digit_t digit_sanitize(input digit_t d);
        return (d > 4'd9) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/sudoku_input_ctrl_btn_repeat.sv
// Rising-edge detect plus frame-counted auto-repeat for a single debounced button.
// o_fire is a one-clk request: the press edge, then each repeat interval while held.
module btn_repeat
    import sudoku_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 30,
    parameter int unsigned REPEAT_RATE  = 6
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    input  logic i_frame_start,
    input  logic i_enable,
    input  logic i_hold_ok,
    output logic o_fire
);

    localparam int unsigned MAX_P = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W = $clog2(MAX_P + 1);

    logic             r_prev;
    logic             r_repeating;
    logic [CNT_W-1:0] r_cnt;

    logic             w_edge;
    logic             w_hold;
    logic [CNT_W-1:0] w_limit;
    logic             w_tick;

    assign w_edge  = i_btn & ~r_prev;
    assign w_hold  = i_enable & i_btn & i_hold_ok;
    assign w_limit = r_repeating ? CNT_W'(REPEAT_RATE - 1) : CNT_W'(REPEAT_DELAY - 1);
    assign w_tick  = w_hold & i_frame_start & (r_cnt == w_limit);
    assign o_fire  = i_enable & (w_edge | w_tick);

    // r_prev tracks the level even while disabled so a button held across a load
    // does not produce a late edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev      <= 1'b0;
            r_repeating <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_prev <= i_btn;
            if (!w_hold) begin
                r_repeating <= 1'b0;
                r_cnt       <= '0;
            end else if (i_frame_start) begin
                if (r_cnt == w_limit) begin
                    r_repeating <= 1'b1;
                    r_cnt       <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sudoku_input_ctrl.sv
// Board state owner: puzzle load from ROM, button actions, frame-synchronous commits.
// Every visible change lands on a frame_start clk (edits) or during LOAD.
module sudoku_input_ctrl
    import sudoku_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 30,
    parameter int unsigned REPEAT_RATE  = 6,
    parameter int unsigned CELLS        = 81
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_frame_start,
    input  logic                  i_btn_up,
    input  logic                  i_btn_down,
    input  logic                  i_btn_left,
    input  logic                  i_btn_right,
    input  logic                  i_btn_inc,
    input  logic                  i_btn_clr,
    input  logic                  i_load_req,
    output logic [6:0]            o_rom_addr,
    input  logic [3:0]            i_rom_data,
    output logic [0:8][0:8][3:0]  o_grid_vals,
    output logic [0:8][0:8]       o_fixed_mask,
    output logic [3:0]            o_cursor_x,
    output logic [3:0]            o_cursor_y,
    output logic                  o_busy
);

    localparam int unsigned LD_CNT_W = $clog2(CELLS + 1);

    ctrl_state_t         r_state;
    ctrl_state_t         w_state_next;
    action_t             r_pending;
    action_t             w_pending_next;
    action_t             w_req;

    grid_t               r_grid;
    mask_t               r_mask;
    logic [3:0]          r_cursor_x;
    logic [3:0]          r_cursor_y;
    logic                r_busy;
    logic [6:0]          r_rom_addr;
    logic [LD_CNT_W-1:0] r_ld_cnt;
    logic [3:0]          r_wr_row;
    logic [3:0]          r_wr_col;

    logic [5:0]          w_btns;
    logic [5:0]          w_fire;
    logic                w_single;
    logic                w_idle;
    logic                w_start_load;
    logic                w_load_wr;
    logic                w_load_done;
    logic                w_commit;
    digit_t              w_rom_digit;
    digit_t              w_cur_digit;
    logic                w_cur_fixed;

    // Bit order: 0 up, 1 down, 2 left, 3 right, 4 inc, 5 clr.
    assign w_btns   = {i_btn_clr, i_btn_inc, i_btn_right, i_btn_left, i_btn_down, i_btn_up};
    assign w_single = $onehot(w_btns);

    for (genvar g = 0; g < 6; g++) begin : g_btn
        btn_repeat #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_btn_repeat (
            .i_clk         (i_clk),
            .i_rst_n       (i_rst_n),
            .i_btn         (w_btns[g]),
            .i_frame_start (i_frame_start),
            .i_enable      (w_idle),
            .i_hold_ok     (w_single),
            .o_fire        (w_fire[g])
        );
    end

    always_comb begin
        w_req = ACT_NONE;
        if      (w_fire[5]) w_req = ACT_CLR;
        else if (w_fire[4]) w_req = ACT_INC;
        else if (w_fire[0]) w_req = ACT_UP;
        else if (w_fire[1]) w_req = ACT_DOWN;
        else if (w_fire[2]) w_req = ACT_LEFT;
        else if (w_fire[3]) w_req = ACT_RIGHT;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (i_load_req) w_state_next = LOAD;
            LOAD:    if (r_ld_cnt == LD_CNT_W'(CELLS)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ROM data for address a is captured when r_ld_cnt == a + 1, so the last
    // write coincides with the return to IDLE.
    always_comb begin
        w_idle       = (r_state == IDLE);
        w_start_load = w_idle & i_load_req;
        w_load_wr    = (r_state == LOAD) & (r_ld_cnt != '0);
        w_load_done  = (r_state == LOAD) & (r_ld_cnt == LD_CNT_W'(CELLS));
        w_commit     = w_idle & ~i_load_req & i_frame_start & (r_pending != ACT_NONE);
    end

    // A commit frees the slot, so a request arriving on that same clk waits for the next frame.
    always_comb begin
        w_pending_next = r_pending;
        if (!w_idle || i_load_req) begin
            w_pending_next = ACT_NONE;
        end else begin
            if (w_commit) w_pending_next = ACT_NONE;
            if (w_pending_next == ACT_NONE) w_pending_next = w_req;
        end
    end

    assign w_rom_digit = digit_sanitize(i_rom_data);
    assign w_cur_digit = r_grid[r_cursor_y][r_cursor_x];
    assign w_cur_fixed = r_mask[r_cursor_y][r_cursor_x];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending  <= ACT_NONE;
            r_busy     <= 1'b0;
            r_rom_addr <= '0;
            r_ld_cnt   <= '0;
            r_wr_row   <= '0;
            r_wr_col   <= '0;
        end else begin
            r_pending <= w_pending_next;
            if (w_start_load) begin
                r_busy     <= 1'b1;
                r_rom_addr <= '0;
                r_ld_cnt   <= '0;
                r_wr_row   <= '0;
                r_wr_col   <= '0;
            end else if (r_state == LOAD) begin
                r_ld_cnt <= r_ld_cnt + 1'b1;
                if (r_rom_addr != 7'(CELLS - 1)) r_rom_addr <= r_rom_addr + 7'd1;
                if (w_load_wr) begin
                    if (r_wr_col == 4'(BOARD_N - 1)) begin
                        r_wr_col <= '0;
                        r_wr_row <= r_wr_row + 4'd1;
                    end else begin
                        r_wr_col <= r_wr_col + 4'd1;
                    end
                end
                if (w_load_done) r_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grid     <= '0;
            r_mask     <= '0;
            r_cursor_x <= '0;
            r_cursor_y <= '0;
        end else if (r_state == LOAD) begin
            if (w_load_wr) begin
                r_grid[r_wr_row][r_wr_col] <= w_rom_digit;
                r_mask[r_wr_row][r_wr_col] <= (w_rom_digit != 4'd0);
            end
            if (w_load_done) begin
                r_cursor_x <= '0;
                r_cursor_y <= '0;
            end
        end else if (w_commit) begin
            unique case (r_pending)
                ACT_UP:    r_cursor_y <= wrap_dec(r_cursor_y);
                ACT_DOWN:  r_cursor_y <= wrap_inc(r_cursor_y);
                ACT_LEFT:  r_cursor_x <= wrap_dec(r_cursor_x);
                ACT_RIGHT: r_cursor_x <= wrap_inc(r_cursor_x);
                ACT_INC: begin
                    if (!w_cur_fixed) r_grid[r_cursor_y][r_cursor_x] <= digit_inc(w_cur_digit);
                end
                ACT_CLR: begin
                    if (!w_cur_fixed) r_grid[r_cursor_y][r_cursor_x] <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_grid_vals  = r_grid;
    assign o_fixed_mask = r_mask;
    assign o_cursor_x   = r_cursor_x;
    assign o_cursor_y   = r_cursor_y;
    assign o_busy       = r_busy;
    assign o_rom_addr   = r_rom_addr;

endmodule

// File: doc/sudoku_input_ctrl.md
Name: sudoku_input_ctrl

Overview:
- Owns the Sudoku board state consumed by the VGA renderer: the 9x9 digit grid, the fixed-cell mask and the cursor position.
- Loads a puzzle from an external puzzle ROM.
- Turns debounced push-button levels into edge-detected, auto-repeating cursor and edit actions.
- Commits every user-visible change only on a frame-start pulse, so the renderer never shows a torn frame.

Parameters:
- REPEAT_DELAY, 30, frames a button must be held before auto-repeat starts.
- REPEAT_RATE, 6, frames between auto-repeat actions once repeating.
- CELLS, 81, number of board cells (9x9); loader address range is 0..CELLS-1.

Ports:
- clk  in  1  system clock (pixel clock domain).
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced button levels.
- btn_inc  in  1  debounced level; increments the cursor cell digit.
- btn_clr  in  1  debounced level; clears the cursor cell.
- load_req  in  1  one-cycle pulse; request a puzzle load.
- rom_addr  out  7  puzzle ROM address, row-major (row*9+col).
- rom_data  in  4  puzzle ROM digit (0 = empty); valid one clk after rom_addr.
- grid_vals  out  4 x [0:8][0:8]  displayed digits.
- fixed_mask  out  1 x [0:8][0:8]  1 = puzzle-given cell, not editable.
- cursor_x, cursor_y  out  4 each  cursor column and row, 0..8.
- busy  out  1  high while loading.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs go to their reset values.
  - grid_vals all 0, fixed_mask all 0.
  - cursor_x = cursor_y = 0, busy = 0, rom_addr = 0.
  - State IDLE; repeat counters, held flags and pending action cleared.
- State IDLE:
  - load_req = 1 -> LOAD. Set rom_addr = 0 and busy = 1 on the next edge.
  - Any pending action is discarded.
- State LOAD:
  - rom_addr increments by 1 each clk from 0 to 80.
  - Data for address a is registered one clk later:
    - grid_vals[a/9][a%9] <= rom_data.
    - fixed_mask[a/9][a%9] <= (rom_data != 0).
  - rom_data values 10..15 are written as 0 with mask 0.
  - After the write for address 80 -> IDLE with busy = 0, cursor reset to (0,0). Total 82 clks from load_req to busy falling.
  - load_req and buttons are ignored during LOAD. Button edges seen in LOAD do not become pending.
- Button processing (IDLE only), evaluated per clk:
  - A rising edge of any button sets the pending action, unless one is already pending.
  - Priority among simultaneous edges: clr > inc > up > down > left > right.
  - Auto-repeat: while the same single button stays high, count frame_start pulses. Re-arm the action after REPEAT_DELAY frames, then every REPEAT_RATE frames. A release resets the counter.
- Commit: on a frame_start clk with an action pending, apply exactly one action and clear pending. At most one action per frame.
  - up: cursor_y = (y==0) ? 8 : y-1.
  - down: cursor_y = (y==8) ? 0 : y+1.
  - left / right: same wrap rule on cursor_x.
  - inc: if !fixed_mask[y][x], digit = (d==9) ? 0 : d+1. Otherwise no change.
  - clr: if !fixed_mask[y][x], digit = 0. Otherwise no change.
- Edge and frame_start in the same clk: the edge becomes pending and commits at the next frame_start, not the current one.
- Outputs are registered. Values change only on a commit clk or during LOAD.

Decomposition:
- Package sudoku_pkg holds:
  - typedef digit_t (logic [3:0]).
  - Typedef for the 9x9 grid and mask arrays.
  - enum action_t {ACT_NONE, ACT_UP, ACT_DOWN, ACT_LEFT, ACT_RIGHT, ACT_INC, ACT_CLR}.
  - enum ctrl_state_t {IDLE, LOAD}.
  - Constants BOARD_N=9, CELLS=81.
- One sub-module, btn_repeat: edge detect plus frame-counted auto-repeat for one button, instantiated 6 times.

Test Plan:
- Reset then load: ROM cell 0 = 5, cell 80 = 0, all others 0 -> busy high 82 clks, grid_vals[0][0]=5, fixed_mask[0][0]=1, grid_vals[8][8]=0, mask 0.
- Wrap: at cursor (0,0), press left, wait one frame_start -> cursor_x=8. Then press up -> cursor_y=8.
- Edit non-fixed cell at (1,0) with digit 9, press inc -> digit 0 after frame_start. Press inc again -> 1. Press clr -> 0.
- Fixed protection: at (0,0) with value 5 and mask 1, press inc and clr -> grid_vals[0][0] stays 5.
- Auto-repeat: hold right for 45 frames from (0,0) -> actions at frames 1, 31, 37, 43 -> cursor_x=4.
- Simultaneous and mid-op: inc and right rise together -> only inc applied that frame. Assert rst_n low mid-LOAD at address 40 -> all outputs immediately 0, busy=0.
